// File: rtl/countdown_timer_if.sv
// Control/preset inputs and remaining-time/status outputs of the countdown timer.
// master drives presets and pulses; slave is the timer itself.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [6:0] set_numb_hour;
  logic [6:0] set_numb_min;
  logic [6:0] set_numb_sec;
  logic       start;
  logic       pause;
  logic [6:0] hour_w;
  logic [6:0] min_w;
  logic [6:0] sec_w;
  logic       running;
  logic       expired;
  logic       done_pulse;

  modport master (
    output tick, load, set_numb_hour, set_numb_min, set_numb_sec, start, pause,
    input  hour_w, min_w, sec_w, running, expired, done_pulse
  );

  modport slave (
    input  tick, load, set_numb_hour, set_numb_min, set_numb_sec, start, pause,
    output hour_w, min_w, sec_w, running, expired, done_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// H:M:S countdown timer with IDLE/RUN/PAUSED/EXPIRED control; all outputs registered, one-cycle latency.
// No backpressure: every tick/load/start/pause pulse is acted on in the cycle it is presented.
module countdown_timer (
  input  logic              sys_clk,
  input  logic              rst_n,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state;
  logic [6:0] hour_q;
  logic [6:0] min_q;
  logic [6:0] sec_q;
  logic       running_q;
  logic       expired_q;
  logic       done_q;

  logic [6:0] ld_hour;
  logic [6:0] ld_min;
  logic [6:0] ld_sec;
  logic       count_zero;
  logic       count_one;

  assign ld_hour    = (bus.set_numb_hour > 7'd23) ? 7'd23 : bus.set_numb_hour;
  assign ld_min     = (bus.set_numb_min  > 7'd59) ? 7'd59 : bus.set_numb_min;
  assign ld_sec     = (bus.set_numb_sec  > 7'd59) ? 7'd59 : bus.set_numb_sec;
  assign count_zero = (hour_q == 7'd0) && (min_q == 7'd0) && (sec_q == 7'd0);
  assign count_one  = (hour_q == 7'd0) && (min_q == 7'd0) && (sec_q == 7'd1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hour_q    <= 7'd0;
      min_q     <= 7'd0;
      sec_q     <= 7'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state     <= IDLE;
        hour_q    <= ld_hour;
        min_q     <= ld_min;
        sec_q     <= ld_sec;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            // start+pause together outside RUN counts as start
            if (bus.start && !count_zero) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else if (bus.tick) begin
              // RUN never holds 0:0:0, so the hour borrow cannot underflow
              if (sec_q != 7'd0) begin
                sec_q <= sec_q - 7'd1;
              end else begin
                sec_q <= 7'd59;
                if (min_q != 7'd0) begin
                  min_q <= min_q - 7'd1;
                end else begin
                  min_q  <= 7'd59;
                  hour_q <= hour_q - 7'd1;
                end
              end
              if (count_one) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.hour_w     = hour_q;
  assign bus.min_w      = min_q;
  assign bus.sec_w      = sec_q;
  assign bus.running    = running_q;
  assign bus.expired    = expired_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench: driver pushes the reference model's expected outputs, monitor pops and compares.
module tb_countdown_timer;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;

  countdown_timer_if bus ();

  countdown_timer dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining time kept as a plain count of seconds
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  int m_rem = 0;
  int m_st  = S_IDLE;

  function automatic logic [23:0] model_out(input bit done);
    logic [23:0] r;
    r = {7'(m_rem / 3600), 7'((m_rem / 60) % 60), 7'(m_rem % 60),
         (m_st == S_RUN), (m_st == S_EXP), done};
    return r;
  endfunction

  task automatic push(input logic [23:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit t, input bit ld, input int h, input int m, input int s,
                       input bit st, input bit ps, input string tag);
    bit done;
    bus.tick          = t;
    bus.load          = ld;
    bus.set_numb_hour = 7'(h);
    bus.set_numb_min  = 7'(m);
    bus.set_numb_sec  = 7'(s);
    bus.start         = st;
    bus.pause         = ps;
    done = 1'b0;
    if (!rst_n) begin
      m_rem = 0;
      m_st  = S_IDLE;
    end else if (ld) begin
      m_rem = (h > 23 ? 23 : h) * 3600 + (m > 59 ? 59 : m) * 60 + (s > 59 ? 59 : s);
      m_st  = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE, S_PAUSE: if (st && m_rem != 0) m_st = S_RUN;
        S_RUN: begin
          if (ps) m_st = S_PAUSE;
          else if (t) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
              m_st = S_EXP;
              done = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    push(model_out(done), tag);
    @(posedge sys_clk);
    #3;
  endtask

  task automatic idle(input string tag);        cycle(0, 0, 0, 0, 0, 0, 0, tag); endtask
  task automatic tk(input string tag);          cycle(1, 0, 0, 0, 0, 0, 0, tag); endtask
  task automatic go(input string tag);          cycle(0, 0, 0, 0, 0, 1, 0, tag); endtask
  task automatic ldv(input int h, input int m, input int s, input string tag);
    cycle(0, 1, h, m, s, 0, 0, tag);
  endtask

  task automatic reset_assert(input string tag);
    m_rem = 0;
    m_st  = S_IDLE;
    push(model_out(1'b0), tag);
    rst_n = 1'b0;
  endtask

  // Monitor: samples 1 time unit after every clock edge or reset assertion
  initial begin
    exp_t        e;
    logic [23:0] got;
    forever begin
      @(posedge sys_clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.hour_w, bus.min_w, bus.sec_w, bus.running, bus.expired, bus.done_pulse};
        checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s @%0t: got %0d:%0d:%0d run=%0b exp=%0b done=%0b, want %0d:%0d:%0d run=%0b exp=%0b done=%0b",
                   e.tag, $time, got[23:17], got[16:10], got[9:3], got[2], got[1], got[0],
                   e.v[23:17], e.v[16:10], e.v[9:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
    bus.set_numb_hour = 0; bus.set_numb_min = 0; bus.set_numb_sec = 0;
    #2;
    reset_assert("reset_async");
    cycle(1, 1, 0, 0, 9, 1, 0, "reset_hold");
    idle("reset_hold");
    rst_n = 1'b1;

    // basic expiry, first edge after release is live
    ldv(0, 0, 3, "load_003");
    go("start_003");
    tk("tick_2"); tk("tick_1"); tk("tick_0_expire");
    idle("done_clear");
    tk("tick_in_expired");
    go("start_in_expired");
    cycle(0, 0, 0, 0, 0, 0, 1, "pause_in_expired");

    // borrow chains
    ldv(1, 0, 0, "load_100"); go("start_100"); tk("borrow_hour");
    ldv(0, 1, 0, "load_010"); go("start_010"); tk("borrow_min");

    // clamp and zero start
    ldv(30, 75, 99, "clamp");
    ldv(0, 0, 0, "load_000");
    go("start_zero");
    cycle(1, 0, 0, 0, 0, 1, 1, "start_pause_zero");

    // pause discards the tick
    ldv(0, 0, 5, "load_005"); go("start_005");
    cycle(1, 0, 0, 0, 0, 0, 1, "pause_with_tick");
    for (int i = 0; i < 10; i++) tk("tick_paused");
    go("resume"); tk("tick_after_resume");
    cycle(1, 0, 0, 0, 0, 1, 1, "start_pause_in_run");

    // load priority over tick in RUN
    cycle(1, 1, 0, 2, 0, 1, 1, "load_prio_run");

    // reset mid-run
    ldv(0, 0, 3, "load_003b"); go("start_003b"); tk("tick_to_002");
    reset_assert("reset_midrun");
    tk("reset_hold_tick");
    rst_n = 1'b1;
    tk("post_reset_tick"); go("post_reset_start"); tk("post_reset_tick2");

    // expiring tick with start, then load+start from EXPIRED
    ldv(0, 0, 1, "load_001"); go("start_001");
    cycle(1, 0, 0, 0, 0, 1, 0, "expire_with_start");
    go("start_expired");
    cycle(0, 1, 0, 0, 1, 1, 0, "load_with_start");
    idle("idle_after_load");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_assert("rand_reset");
        tk("rand_reset_hold");
        rst_n = 1'b1;
      end else begin
        int h, m, s;
        h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : 0;
        m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
        s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
        if (h > 23 || m > 59) begin
          // keep most random loads short enough to reach expiry
          if ($urandom_range(0, 1) == 0) begin h = 0; m = 0; end
        end
        cycle($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, h, m, s,
              $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, "random");
      end
    end

    idle("drain");
    idle("drain");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL provide the ports: sys_clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide the ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide the ports: tick  in  1  one-cycle enable, one per elapsed second.
REQ-004 SHALL provide the ports: load  in  1  one-cycle pulse, loads the preset value.
REQ-005 SHALL provide the ports: set_numb_hour  in  7  preset hours; set_numb_min  in  7  preset minutes; set_numb_sec  in  7  preset seconds.
REQ-006 SHALL provide the ports: start  in  1  one-cycle pulse, run/resume; pause  in  1  one-cycle pulse, halt.
REQ-007 SHALL provide the ports: hour_w  out  7; min_w  out  7; sec_w  out  7  remaining time, binary.
REQ-008 SHALL provide the ports: running  out  1  high in RUN state.
REQ-009 SHALL provide the ports: expired  out  1  high in EXPIRED state; done_pulse  out  1  one-cycle pulse on expiry.

Function
REQ-010 SHALL implement a state machine with four states: IDLE, RUN, PAUSED, EXPIRED.
REQ-011 load SHALL capture the preset in any state and go to IDLE, with each field clamped: hours >23 to 23, minutes >59 to 59, seconds >59 to 59.
REQ-012 load SHALL have priority over start, pause and tick in the same cycle.
REQ-013 start in IDLE or PAUSED with a nonzero count SHALL go to RUN; start with count 0:0:0 SHALL be ignored, with no done_pulse.
REQ-014 pause in RUN SHALL go to PAUSED, and that cycle's tick SHALL be discarded.
REQ-015 start and pause together SHALL be treated as pause in RUN and as start otherwise.
REQ-016 A tick in RUN SHALL decrement the count by one second with borrow: sec 0 -> 59 with min-1; min 0 -> 59 with hour-1.
REQ-017 A tick SHALL leave the count unchanged in IDLE, PAUSED and EXPIRED.
REQ-018 A tick in RUN at count 0:0:1 SHALL set the count to 0:0:0, go to EXPIRED, and assert done_pulse for exactly the next cycle (registered, one-cycle latency).
REQ-019 A start in the same cycle as the expiring tick SHALL be ignored.
REQ-020 EXPIRED SHALL hold the count at 0:0:0 until load, and start or pause in EXPIRED SHALL be ignored.
REQ-021 The count SHALL never underflow: hour_w, min_w and sec_w stay within 0..23 / 0..59 / 0..59 at all times.
REQ-022 The outputs SHALL be registered, with running = (state==RUN) and expired = (state==EXPIRED).
REQ-023 done_pulse SHALL NOT re-assert while the block remains in EXPIRED.
REQ-024 Minute and hour fields SHALL change only on the same edge as the seconds borrow that causes them.

Reset
REQ-025 rst_n low SHALL immediately clear: state IDLE, hour_w/min_w/sec_w = 0, running = 0, expired = 0, done_pulse = 0.
REQ-026 Reset asserted mid-RUN SHALL abort the countdown with no done_pulse, and the block SHALL stay idle after release until load.
REQ-027 The first edge after rst_n rises SHALL be processed normally.

Verification
REQ-028 SHALL cover: load 0:0:3, start, 3 ticks -> sec 2,1,0; expired=1; done_pulse high exactly 1 cycle after the third tick.
REQ-029 SHALL cover: load 1:0:0, start, 1 tick -> 0:59:59; load 0:1:0, start, 1 tick -> 0:0:59.
REQ-030 SHALL cover: load 30:75:99 -> 23:59:59; start with count 0:0:0 -> stays IDLE, no done_pulse.
REQ-031 SHALL cover: RUN at 0:0:5, pause with tick in the same cycle -> 0:0:5 held, running=0; 10 ticks -> no change; start, tick -> 0:0:4.
REQ-032 SHALL cover: rst_n low at 0:0:2 in RUN -> all outputs 0 asynchronously; release, ticks -> no change, no done_pulse.
REQ-033 SHALL cover: EXPIRED, start -> ignored; load 0:0:1 together with start -> IDLE at 0:0:1, running=0.
